aes_sbox: RTL and testbench
===========================

Name: aes_sbox

Overview:
- Registered AES forward S-box (FIPS-197 SubBytes) for a single byte.
- Maps one 8-bit input to its S-box substitute through a 256-entry lookup, then registers the result.
- Building block for the SubBytes stage of the AES encryption datapath; 16 instances or time-multiplexed use cover one state.

Parameters:
- None. The table is fixed by FIPS-197 and the width is fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_byte is valid this cycle
- in_byte  input  8  byte to substitute
- out_valid  output  1  out_byte holds a fresh result
- out_byte  output  8  S-box substitute of the captured in_byte

Behaviour:
- One clock, clk, rising edge only.
- rst is synchronous and active-high. It is sampled on the clk edge and has priority over all other inputs.
- Reset values: out_byte = 8'h00, out_valid = 0.
- 8'h00 is a deliberate reset value: it differs from S(00) = 63, so reset is distinguishable from a real result.
- Lookup: sbox(x) is the FIPS-197 forward S-box, i.e. multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1 (inverse of 0 taken as 0), followed by the affine transform with constant 0x63.
- The lookup is implemented as a constant 256-entry table (case or ROM), with no arithmetic.
- Latency is 1 cycle. For in_valid = 1 sampled at edge N, out_byte = sbox(in_byte) and out_valid = 1 after edge N.
- For in_valid = 0 sampled at an edge, out_valid = 0 after that edge and out_byte holds its previous value.
- Throughput is one byte per cycle. Back-to-back valid inputs produce back-to-back results; there is no backpressure.
- Reset asserted mid-stream: the in-flight result is discarded and the outputs return to their reset values at that edge.
- The pipeline resumes on the first edge with rst = 0.
- No X propagation from the table: every 8-bit input has a defined entry. The default/others branch is not reachable but is coded to return 8'h00.
- The output is purely a function of the registered state; there is no combinational path from in_byte to out_byte.

Decomposition:
- Shared package aes_pkg holds:
  - the SBOX constant array (256 x 8 bits);
  - the byte typedef (8-bit logic vector);
  - later, the inverse table for the decryption path.
- One natural sub-module: aes_sbox_lut, a purely combinational 8-in/8-out table lookup.
- aes_sbox wraps aes_sbox_lut with the valid/data register stage. The rest of the AES core reuses the same LUT unregistered.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in_valid = 1, in_byte = 8'h23 -> out_valid = 0 and out_byte = 8'h00 throughout; the first post-reset edge with the same input gives out_byte = 8'h26 and out_valid = 1.
- Known vectors, back-to-back with in_valid = 1 on consecutive cycles. Each result appears one cycle later, in order:
  - 00 -> 63
  - 23 -> 26
  - 56 -> B1
  - A3 -> 0A
  - 4E -> 2F
  - 19 -> D4
  - FF -> 16
  - CC -> 4B
  - DF -> 9E
- Hold behaviour: apply 8'h53 valid, then in_valid = 0 with in_byte = 8'hFF -> out_byte = ED with out_valid = 1, then out_byte still ED with out_valid = 0.
- Exhaustive: sweep in_byte 00..FF valid -> every output matches a reference model computing the GF(2^8) inverse plus affine transform. Spot-check 01 -> 7C, 10 -> CA, 80 -> CD.
- Mid-stream reset: stream 3 valid bytes and assert rst on the 2nd edge -> the outputs are 00/0 on that edge with no stale result afterwards; the stream resumes correctly once rst is released.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type and the FIPS-197 forward S-box table.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox_lut.sv
// Combinational forward S-box lookup; shared unregistered by the rest of the core.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] sub_o
);

  // Decoded as a mux over every entry; the fall-through 8'h00 is unreachable.
  always_comb begin
    sub_o = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if (byte_i == 8'(i)) sub_o = SBOX[i];
    end
  end

endmodule

// File: rtl/aes_sbox.sv
// Registered single-byte forward S-box: one-cycle latency, one byte per cycle.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  output logic [7:0] out_byte
);

  byte_t sub;
  byte_t byte_d, byte_q;
  logic  valid_d, valid_q;

  aes_sbox_lut u_lut (
    .byte_i (in_byte),
    .sub_o  (sub)
  );

  // Data holds when no valid byte arrives; 8'h00 reset differs from S(00).
  always_comb begin
    valid_d = in_valid;
    byte_d  = in_valid ? sub : byte_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      byte_q  <= byte_d;
    end
  end

  assign out_valid = valid_q;
  assign out_byte  = byte_q;

endmodule

// File: tb/tb_aes_sbox.sv
// Directed bench for aes_sbox with an arithmetic GF(2^8) reference and a result queue.
module tb_aes_sbox;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       out_valid;
  logic [7:0] out_byte;

  int passes = 0;
  int checks = 0;

  logic [7:0] ref_tab [256];
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  logic       exp_v;

  always #5 clk = ~clk;

  aes_sbox dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_byte  (out_byte)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Drive one cycle; when a valid byte enters, its expected result is queued.
  task automatic step(input logic r, input logic v, input logic [7:0] b,
                      input logic [7:0] expv, input string tag);
    rst = r; in_valid = v; in_byte = b;
    if (v && !r) exp_q.push_back(expv);
    @(posedge clk); #1;
    if (r) begin
      exp_q.delete();
      exp_v = 1'b0;
      exp_b = 8'h00;
    end else begin
      exp_v = v;
      if (v) begin
        if (exp_q.size() == 0) begin
          checks++;
          $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else exp_b = exp_q.pop_front();
      end
    end
    chk({tag, "_valid"}, {7'd0, out_valid}, {7'd0, exp_v});
    chk({tag, "_byte"}, out_byte, exp_b);
  endtask

  logic [7:0] kin  [9];
  logic [7:0] kout [9];

  initial begin
    kin  = '{8'h00, 8'h23, 8'h56, 8'ha3, 8'h4e, 8'h19, 8'hff, 8'hcc, 8'hdf};
    kout = '{8'h63, 8'h26, 8'hb1, 8'h0a, 8'h2f, 8'hd4, 8'h16, 8'h4b, 8'h9e};
    for (int i = 0; i < 256; i++) ref_tab[i] = sbox_model(8'(i));
    exp_v = 1'b0; exp_b = 8'h00;

    // Reset held with a live input
    step(1'b1, 1'b1, 8'h23, 8'h00, "rst0");
    step(1'b1, 1'b1, 8'h23, 8'h00, "rst1");
    step(1'b0, 1'b1, 8'h23, 8'h26, "post_rst");

    // Known vectors, back-to-back
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, kin[i], kout[i], "known");

    // Hold: invalid cycle keeps data, drops valid
    step(1'b0, 1'b1, 8'h53, 8'hed, "hold_load");
    step(1'b0, 1'b0, 8'hff, 8'h00, "hold_idle");
    step(1'b0, 1'b0, 8'h00, 8'h00, "hold_idle2");

    // Spot checks against literal values
    step(1'b0, 1'b1, 8'h01, 8'h7c, "spot01");
    step(1'b0, 1'b1, 8'h10, 8'hca, "spot10");
    step(1'b0, 1'b1, 8'h80, 8'hcd, "spot80");

    // Exhaustive sweep against the arithmetic model
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 8'(i), ref_tab[i], "sweep");

    // Mid-stream reset on the second edge, then resume
    step(1'b0, 1'b1, 8'h11, ref_tab[8'h11], "mid0");
    step(1'b1, 1'b1, 8'h22, 8'h00, "mid_rst");
    step(1'b0, 1'b0, 8'h33, 8'h00, "mid_idle");
    step(1'b0, 1'b1, 8'h33, 8'hc3, "mid_resume0");
    step(1'b0, 1'b1, 8'h44, 8'h1b, "mid_resume1");
    step(1'b0, 1'b0, 8'h00, 8'h00, "tail");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
